dm_cache_ctrl: RTL and testbench
================================

# dm_cache_ctrl

Read-only, direct-mapped cache controller placed between a word requester and the 128-bit line-read port of the data memory (15-bit word address, 32-bit words, 4-word lines). On a hit it returns the word from its own line store. On a miss it drives a line-aligned address to the memory, waits a fixed latency, fills the line and returns the word. It also flushes all lines and keeps saturating hit/miss counters.

## Interface
- LINES, 1024, number of cache lines; power of two, 1..8192; IDX_W = log2(LINES), TAG_W = 13 - IDX_W
- MEM_LATENCY, 4, cycles memory data needs to settle after mem_addr changes; >= 1
- CNT_W, 16, width of hit/miss counters
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  read request present
- req_addr  in  15  word address
- req_ready  out  1  controller accepts a request this cycle
- flush  in  1  invalidate all lines
- resp_valid  out  1  one-cycle pulse: resp_data valid
- resp_data  out  32  returned word
- resp_hit  out  1  qualifies resp_valid: 1 hit, 0 miss
- mem_addr  out  15  line-aligned address to data memory
- mem_data  in  128  line from memory; word at mem_addr in [127:96], +1 in [95:64], +2 in [63:32], +3 in [31:0]
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

## Operation
- Address split: offset = addr[1:0], index = addr[IDX_W+1:2], tag = addr[14:IDX_W+2].
- Word select: line[127-32*offset -: 32].
- State IDLE:
  - req_ready = (state == IDLE) & ~flush.
  - flush has priority: all valid bits clear in one edge, state stays IDLE, no request accepted.
  - Otherwise req_valid & req_ready latches the address -> COMPARE.
- State COMPARE:
  - Hit (valid[index] and tag match) -> register resp_valid=1, resp_hit=1, resp_data=selected word; hit_count++ (saturate at all-ones) -> IDLE.
  - Miss -> register mem_addr = {tag, index, 2'b00}; load latency counter with MEM_LATENCY-1 -> FETCH.
- State FETCH:
  - Decrement counter each edge.
  - At the edge where counter==0: write mem_data and tag into line[index], set valid[index]; register resp_valid=1, resp_hit=0, resp_data = word from mem_data; miss_count++ (saturating) -> IDLE.
- flush outside IDLE is ignored; it must be held until IDLE to take effect.
- Responses have no backpressure.
- mem_addr holds its value between misses.

## Timing
- Reset values: state IDLE, all valid bits 0, resp_valid 0, resp_hit 0, resp_data 0, mem_addr 0, hit_count 0, miss_count 0.
- Tag and data arrays are not reset.
- req_ready is 1 in the first cycle after reset release if flush is 0.
- Accept at edge E0:
  - Hit: resp_valid is high for exactly the one cycle after E1.
  - Miss: resp_valid is high for the one cycle after E(1+MEM_LATENCY); mem_addr is valid from E1.
- Throughput: next accept at E2 at the earliest after a hit, and at the edge after the response following a miss (req_ready is high during the response cycle).
- Reset mid-COMPARE or mid-FETCH: abort immediately, no response, the line stays invalid.
- Requests at different tags on the same index replace the line. No write path; memory contents are read-only.

## Structure
- Package dm_cache_pkg:
  - ADDR_W=15, WORD_W=32, LINE_W=128, WORDS_PER_LINE=4, OFFSET_W=2
  - state enum {IDLE, COMPARE, FETCH}
  - word-select function
- Sub-module dm_line_store:
  - tag and data arrays, LINES deep, asynchronous read by index, synchronous write
  - valid vector stays in the controller for one-cycle flush

## Test plan
Memory is modelled with mem[i] = i, LINES=1024, MEM_LATENCY=4.
- After reset, read 0x0005 -> mem_addr=0x0004 at E1; resp_valid after E5, resp_data=0x00000005, resp_hit=0, miss_count=1.
- Then read 0x0006 -> resp after E1, resp_data=0x00000006, resp_hit=1, hit_count=1, mem_addr unchanged.
- Read 0x1005 (same index 1, tag 1) -> miss, mem_addr=0x1004, resp_data=0x00001005. Then read 0x0005 -> miss again, miss_count=3.
- Pulse flush in IDLE together with req_valid -> req_ready=0 that cycle, no accept. Then read 0x1006 -> miss, resp_data=0x00001006.
- Deassert rst_n two cycles into FETCH of read 0x0008 -> no resp_valid, outputs at reset values. After release, req_ready=1 and read 0x0009 misses.
- CNT_W=2: one miss then five hits to the same line -> hit_count=3 (saturated), miss_count=1.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared widths, FSM states, response payload and word-select helper for the
// direct-mapped read-only cache controller.
package dm_cache_pkg;

   localparam int unsigned ADDR_W         = 15;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned LINE_W         = 128;
   localparam int unsigned WORDS_PER_LINE = 4;
   localparam int unsigned OFFSET_W       = 2;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      FETCH
   } state_t;

   typedef struct packed {
      logic              hit;
      logic [WORD_W-1:0] data;
   } resp_t;

   // Word 0 of a line sits in the top 32 bits.
   function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0]   line,
                                                  input logic [OFFSET_W-1:0] off);
      logic [WORD_W-1:0] w;
      case (off)
         2'd0:    w = line[127:96];
         2'd1:    w = line[95:64];
         2'd2:    w = line[63:32];
         default: w = line[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/dm_cache_if.sv
// Requester and memory-side signals of the cache controller.
interface dm_cache_if;
   import dm_cache_pkg::*;

   logic                req_valid;
   logic [ADDR_W-1:0]   req_addr;
   logic                req_ready;
   logic                resp_valid;
   logic [WORD_W-1:0]   resp_data;
   logic                resp_hit;
   logic [ADDR_W-1:0]   mem_addr;
   logic [LINE_W-1:0]   mem_data;

   modport master (
      output req_valid, req_addr, mem_data,
      input  req_ready, resp_valid, resp_data, resp_hit, mem_addr
   );

   modport slave (
      input  req_valid, req_addr, mem_data,
      output req_ready, resp_valid, resp_data, resp_hit, mem_addr
   );
endinterface

// File: rtl/dm_line_store.sv
// Tag and data arrays: asynchronous read and synchronous write at one index.
module dm_line_store
   import dm_cache_pkg::*;
#(
   parameter int unsigned LINES = 1024,
   parameter int unsigned IDX_W = 10,
   parameter int unsigned TAG_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [TAG_W-1:0]  wtag,
   input  logic [LINE_W-1:0] wline,
   output logic [TAG_W-1:0]  rtag_c,
   output logic [LINE_W-1:0] rline_c
);

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINE_W-1:0] data_mem [LINES];

   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[idx]  <= wtag;
         data_mem[idx] <= wline;
      end
   end

   assign rtag_c  = tag_mem[idx];
   assign rline_c = data_mem[idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read-only cache controller with one-cycle flush and
// saturating hit/miss counters.
module dm_cache_ctrl
   import dm_cache_pkg::*;
#(
   parameter int unsigned LINES       = 1024,
   parameter int unsigned MEM_LATENCY = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   dm_cache_if.slave        bus,
   input  logic             flush,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int unsigned IDX_BITS = $clog2(LINES);
   localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
   localparam int unsigned TAG_BITS = ADDR_W - OFFSET_W - IDX_BITS;
   localparam int unsigned TAG_W    = (TAG_BITS > 0) ? TAG_BITS : 1;
   localparam int unsigned LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [LINES-1:0]  valid_q;
   logic              resp_valid_q, resp_valid_d;
   resp_t             resp_q, resp_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              accept, flush_all, fill_we, hit_inc, miss_inc;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag, stored_tag_c;
   logic [LINE_W-1:0] stored_line_c;
   logic              line_hit_c;

   // Degenerate LINES (1 or 8192) keep 1-bit fields that mask/shift to zero.
   assign idx        = IDX_W'(addr_q >> OFFSET_W) & IDX_W'(LINES - 1);
   assign tag        = TAG_W'(addr_q >> (OFFSET_W + IDX_BITS));
   assign line_hit_c = valid_q[idx] & (stored_tag_c == tag);

   dm_line_store #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_store (
      .clk     (clk),
      .we      (fill_we),
      .idx     (idx),
      .wtag    (tag),
      .wline   (bus.mem_data),
      .rtag_c  (stored_tag_c),
      .rline_c (stored_line_c)
   );

   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      resp_valid_d = 1'b0;
      resp_d       = resp_q;
      mem_addr_d   = mem_addr_q;
      accept       = 1'b0;
      flush_all    = 1'b0;
      fill_we      = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush) begin
               flush_all = 1'b1;
            end else if (bus.req_valid) begin
               accept  = 1'b1;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (line_hit_c) begin
               resp_valid_d = 1'b1;
               resp_d.hit   = 1'b1;
               resp_d.data  = word_sel(stored_line_c, addr_q[OFFSET_W-1:0]);
               hit_inc      = 1'b1;
               state_d      = IDLE;
            end else begin
               mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
               lat_d      = LAT_W'(MEM_LATENCY - 1);
               state_d    = FETCH;
            end
         end
         FETCH: begin
            // Memory data has settled once the counter has run down.
            if (lat_q == '0) begin
               fill_we      = 1'b1;
               resp_valid_d = 1'b1;
               resp_d.hit   = 1'b0;
               resp_d.data  = word_sel(bus.mem_data, addr_q[OFFSET_W-1:0]);
               miss_inc     = 1'b1;
               state_d      = IDLE;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         lat_q        <= '0;
         valid_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
         mem_addr_q   <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         resp_valid_q <= resp_valid_d;
         resp_q       <= resp_d;
         mem_addr_q   <= mem_addr_d;
         if (accept) begin
            addr_q <= bus.req_addr;
         end
         if (flush_all) begin
            valid_q <= '0;
         end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
         end
         if (hit_inc && (hit_count != '1)) begin
            hit_count <= hit_count + CNT_W'(1);
         end
         if (miss_inc && (miss_count != '1)) begin
            miss_count <= miss_count + CNT_W'(1);
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE) & ~flush;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_q.data;
   assign bus.resp_hit   = resp_q.hit;
   assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench: driver models the cache abstractly and queues expected
// responses; a monitor checks each response against the queue.
module tb_dm_cache_ctrl;
   import dm_cache_pkg::*;

   localparam int unsigned LINES = 1024;
   localparam int unsigned LAT   = 4;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [15:0] hit_count, miss_count;
   logic [1:0]  hit_count2, miss_count2;

   dm_cache_if bus ();
   dm_cache_if bus2 ();

   dm_cache_ctrl #(.LINES(LINES), .MEM_LATENCY(LAT), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .flush      (flush),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   dm_cache_ctrl #(.LINES(LINES), .MEM_LATENCY(LAT), .CNT_W(2)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus2),
      .flush      (flush),
      .hit_count  (hit_count2),
      .miss_count (miss_count2)
   );

   assign bus2.req_valid = bus.req_valid;
   assign bus2.req_addr  = bus.req_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory with mem[i] = i; data is corrupted until LAT cycles after mem_addr moves.
   function automatic logic [127:0] line_of(input logic [14:0] a);
      logic [127:0] l;
      for (int w = 0; w < 4; w++) l[127-32*w -: 32] = 32'(a) + 32'(w);
      return l;
   endfunction

   logic [14:0] last1 = '0, last2 = '0;
   int          age1 = 1000, age2 = 1000;

   always @(negedge clk) begin
      if (bus.mem_addr !== last1) begin
         last1 = bus.mem_addr;
         age1  = 1;
      end else if (age1 < 1000) age1++;
      bus.mem_data = (age1 >= int'(LAT)) ? line_of(last1) : ~line_of(last1);
   end

   always @(negedge clk) begin
      if (bus2.mem_addr !== last2) begin
         last2 = bus2.mem_addr;
         age2  = 1;
      end else if (age2 < 1000) age2++;
      bus2.mem_data = (age2 >= int'(LAT)) ? line_of(last2) : ~line_of(last2);
   end

   // Reference model: which line tag each index holds, plus running counts.
   typedef struct {
      logic [31:0] data;
      logic        hit;
      logic [14:0] maddr;
      int          hits;
      int          misses;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   bit          mvalid [LINES];
   int          mtag   [LINES];
   int          hits, misses;
   logic [14:0] last_line;

   task automatic model_reset();
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      hits      = 0;
      misses    = 0;
      last_line = '0;
   endtask

   task automatic send(input logic [14:0] a, output int acc);
      int w;
      w   = 0;
      acc = -1;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      while (bus.req_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) begin
         chk("accept_timeout", 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic request(input logic [14:0] a);
      int   acc, idx, tg;
      exp_t e;
      send(a, acc);
      if (acc < 0) return;
      idx   = (int'(a) / 4) % int'(LINES);
      tg    = int'(a) / (4 * int'(LINES));
      e.hit = mvalid[idx] && (mtag[idx] == tg);
      if (e.hit) hits++;
      else begin
         misses++;
         mvalid[idx] = 1'b1;
         mtag[idx]   = tg;
         last_line   = a & 15'h7FFC;
      end
      e.data   = 32'(a);
      e.maddr  = last_line;
      e.hits   = hits;
      e.misses = misses;
      e.cyc    = acc + (e.hit ? 1 : 1 + int'(LAT));
      q.push_back(e);
   endtask

   task automatic do_flush();
      int w;
      w = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      flush         = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 15'($urandom);
      #1 chk("flush_blocks_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      #1;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
   endtask

   // Monitor: every response must match the oldest expectation, on time.
   always @(negedge clk) begin
      exp_t e;
      if (bus.resp_valid === 1'b1) begin
         if (q.size() == 0) chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
         else begin
            e = q.pop_front();
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            chk("resp_data", bus.resp_data, e.data);
            chk("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e.maddr));
            chk("hit_count", 32'(hit_count), 32'(e.hits));
            chk("miss_count", 32'(miss_count), 32'(e.misses));
            chk("hit_count_sat2", 32'(hit_count2), 32'((e.hits > 3) ? 3 : e.hits));
            chk("miss_count_sat2", 32'(miss_count2), 32'((e.misses > 3) ? 3 : e.misses));
            chk("resp_data2", bus2.resp_data, e.data);
         end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
         chk("missing_resp", 32'(bus.resp_valid), 32'd1);
         void'(q.pop_front());
      end
   end

   initial begin
      int          acc, w;
      logic [14:0] a;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
      chk("rst_resp_data", bus.resp_data, 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_hit_count", 32'(hit_count), 32'd0);
      chk("rst_miss_count", 32'(miss_count), 32'd0);
      rst_n = 1'b1;
      #1 chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

      // Directed sequence: fill, hit, conflict replace, refill, flush.
      request(15'h0005);
      request(15'h0006);
      request(15'h1005);
      request(15'h0005);
      do_flush();
      request(15'h1006);

      // Reset two cycles into FETCH aborts the miss.
      send(15'h0008, acc);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("abort_hit_count", 32'(hit_count), 32'd0);
      chk("abort_miss_count", 32'(miss_count), 32'd0);
      chk("abort_miss_count2", 32'(miss_count2), 32'd0);
      chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // One miss then five hits: the 2-bit counter saturates at 3.
      request(15'h0009);
      request(15'h0008);
      request(15'h000A);
      request(15'h000B);
      request(15'h0009);
      request(15'h0008);

      // Random traffic over a few tags and indices to force conflicts.
      for (int i = 0; i < 200; i++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r == 0) do_flush();
         else begin
            a = 15'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) |
                    $urandom_range(0, 3));
            if (r == 1) a = 15'($urandom);
            request(a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      w = 0;
      while (q.size() > 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);
      @(negedge clk);
      chk("final_hit_count", 32'(hit_count), 32'(hits));
      chk("final_miss_count", 32'(miss_count), 32'(misses));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
